dac_tlv5618_ctrl: RTL and testbench
===================================

// Module: dac_tlv5618_ctrl
// PURPOSE
//  Frame sequencer placed directly upstream of the TLV5618 SPI serializer.
//  - Accepts one 12-bit sample pair (channel A, channel B) per valid/ready handshake.
//  - Builds the two 16-bit TLV5618 command words: B to buffer, then A with B updated from the buffer.
//  - Issues each word to the serializer as a start/done transaction, so both DAC outputs change together.
// PARAMETERS
//  SpeedFast  1  SPD bit (D14) in every command word; 1 = fast mode, 0 = slow mode
//  GapCycles  2  idle clk cycles between dac_done and the next dac_start; legal range 1..15
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  s_valid      in   1   sample pair valid
//  s_ready      out  1   block can accept a pair
//  s_data_a     in   12  channel A code
//  s_data_b     in   12  channel B code
//  busy         out  1   a frame pair is in progress
//  dac_start    out  1   one-cycle start pulse to the serializer (its sending_start)
//  dac_data     out  16  command word, held stable from dac_start until dac_done
//  dac_done     in   1   one-cycle frame-complete pulse from the serializer (its sending_done)
// BEHAVIOUR
//  Reset values: s_ready=0, busy=0, dac_start=0, dac_data=16'h0000; FSM=IDLE; A/B latches=0.
//  Word format {R1,SPD,PWR,R0,code[11:0]}:
//    WB = {0,SpeedFast,0,1,b}   (write B buffer)
//    WA = {1,SpeedFast,0,0,a}   (write A, update B from buffer)
//  FSM states: IDLE, START_B, WAIT_B, GAP, START_A, WAIT_A, HOLD.
//  IDLE
//    - s_ready=1.
//    - On s_valid&&s_ready: latch a and b, go to START_B.
//  START_B
//    - dac_data<=WB and dac_start=1 for exactly one cycle; then WAIT_B.
//  WAIT_B
//    - Wait for dac_done, then GAP; gap counter loads GapCycles-1.
//  GAP
//    - Count down to 0, then START_A.
//  START_A
//    - dac_data<=WA, one-cycle dac_start; then WAIT_A.
//  WAIT_A
//    - On dac_done, go to HOLD (counter reloaded).
//  HOLD
//    - Count down to 0, then IDLE.
//    - Guarantees >= GapCycles cycles before the next START_B, because the serializer needs >= 1 idle cycle after done.
//  Latency: handshake at edge k -> dac_start high in cycle k+1, with dac_data=WB valid in the same cycle.
//  s_ready is 0 in every state except IDLE; no input buffering; s_data_* are ignored while s_ready=0.
//  busy = (state != IDLE).
//  dac_done outside WAIT_B/WAIT_A is ignored.
//  No timeout: WAIT_* holds indefinitely without dac_done.
//  dac_start never asserts in two consecutive cycles.
//  dac_data changes only on entry to START_*.
//  Mid-operation rst_n assert: immediate return to reset values.
//    - The serializer shares rst_n, so no partial frame is resumed.
// CONFIGURATION
//  DAC_CTRL_PWRDN_EN defined:
//    - Adds input port pwrdn_req (1 bit) and state START_P.
//    - In IDLE, pwrdn_req=1 has priority over s_valid: s_ready=0 and the block goes to START_P.
//    - START_P sends word {0,SpeedFast,1,0,12'h000} (PWR=1).
//    - The sequence then continues through WAIT_A and HOLD to IDLE.
//    - While pwrdn_req stays 1, no further frames are sent; s_ready stays 0.
//    - The next sample pair after release powers the device back up; PWR=0 in all normal words.
//  DAC_CTRL_PWRDN_EN undefined:
//    - No pwrdn_req port; behaviour exactly as above.
// TESTING
//  Bench models the serializer with a done pulse N cycles after start.
//  1. Reset: rst_n=0 -> all outputs 0, s_ready=0; release -> s_ready=1 on the next cycle.
//  2. Single pair: SpeedFast=1, a=12'h123, b=12'hABC.
//     -> dac_data=16'h5ABC with start, then 16'hC123.
//     -> Exactly GapCycles idle cycles between the first dac_done and the second start.
//  3. Back-to-back: s_valid held with 3 pairs.
//     -> 6 frames in B,A order; s_ready low for the whole of each pair.
//     -> >= GapCycles between every done and the next start.
//  4. Spurious dac_done in IDLE and GAP -> no state change, no dac_start.
//  5. rst_n pulsed while in WAIT_B -> outputs at reset values; next pair restarts with WB.
//  6. DAC_CTRL_PWRDN_EN: pwrdn_req=1 with s_valid=1 in IDLE.
//     -> single frame 16'h6000, no sample frames, s_ready=0.
//     -> After release, pair a=0,b=12'hFFF gives 16'h5FFF then 16'hC000.

Source files
------------

// File: rtl/dac_tlv5618_ctrl.sv
// rtl/dac_tlv5618_ctrl.sv - TLV5618 frame sequencer feeding the SPI serializer
//
// Purpose:
//   Takes one 12-bit sample pair (A, B) per valid/ready handshake. It sends two
//   command words to the serializer. The first word writes B into the DAC
//   buffer. The second word writes A and updates B from the buffer, so both
//   outputs change together. Each word is a start/done transaction.
//
// Optional build macro:
//   DAC_CTRL_PWRDN_EN - adds the pwrdn_req input and a power-down word sequence.
//
// Ports:
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   s_valid    in   1   sample pair valid
//   s_ready    out  1   block can accept a pair (IDLE only)
//   s_data_a   in   12  channel A code
//   s_data_b   in   12  channel B code
//   busy       out  1   a frame pair is in progress
//   dac_start  out  1   one-cycle start pulse to the serializer
//   dac_data   out  16  command word, stable from dac_start until dac_done
//   dac_done   in   1   one-cycle frame-complete pulse from the serializer
//   pwrdn_req  in   1   power-down request (DAC_CTRL_PWRDN_EN only)

module dac_tlv5618_ctrl #(
  parameter bit          SpeedFast = 1'b1,
  parameter int unsigned GapCycles = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [11:0] s_data_a,
  input  logic [11:0] s_data_b,
  output logic        busy,
  output logic        dac_start,
  output logic [15:0] dac_data,
  input  logic        dac_done
`ifdef DAC_CTRL_PWRDN_EN
  ,
  input  logic        pwrdn_req
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    START_B,
    WAIT_B,
    GAP,
    START_A,
    WAIT_A,
    HOLD
`ifdef DAC_CTRL_PWRDN_EN
    ,
    START_P
`endif
  } state_e;

  localparam logic [3:0] GapLoad = 4'(GapCycles - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [11:0] a_q;
  logic        s_ready_q;
  logic        dac_start_q;
  logic [15:0] dac_data_q;
  logic        accept;

`ifdef DAC_CTRL_PWRDN_EN
  // Set once the power-down word has gone out. It stops the word from being
  // resent for as long as pwrdn_req stays high.
  logic pd_sent_q;
  logic pd_go;

  // A power-down request masks s_ready, so it wins over a pending s_valid.
  assign s_ready = s_ready_q & ~pwrdn_req;
  assign pd_go   = (state_q == IDLE) && pwrdn_req && !pd_sent_q;
`else
  assign s_ready = s_ready_q;
`endif

  assign accept    = s_valid && s_ready;
  assign busy      = (state_q != IDLE);
  assign dac_start = dac_start_q;
  assign dac_data  = dac_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      a_q         <= 12'd0;
      s_ready_q   <= 1'b0;
      dac_start_q <= 1'b0;
      dac_data_q  <= 16'h0000;
`ifdef DAC_CTRL_PWRDN_EN
      pd_sent_q   <= 1'b0;
`endif
    end else begin
      dac_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          s_ready_q <= 1'b1;
`ifdef DAC_CTRL_PWRDN_EN
          if (!pwrdn_req) begin
            pd_sent_q <= 1'b0;
          end
          if (pd_go) begin
            pd_sent_q   <= 1'b1;
            s_ready_q   <= 1'b0;
            dac_start_q <= 1'b1;
            dac_data_q  <= {1'b0, SpeedFast, 1'b1, 1'b0, 12'h000};
            state_q     <= START_P;
          end else
`endif
          if (accept) begin
            // B goes straight into the word register. Only A must wait for
            // the second frame.
            a_q         <= s_data_a;
            s_ready_q   <= 1'b0;
            dac_start_q <= 1'b1;
            dac_data_q  <= {1'b0, SpeedFast, 1'b0, 1'b1, s_data_b};
            state_q     <= START_B;
          end
        end
        START_B: state_q <= WAIT_B;
        WAIT_B: begin
          if (dac_done) begin
            cnt_q   <= GapLoad;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (cnt_q == 4'd0) begin
            dac_start_q <= 1'b1;
            dac_data_q  <= {1'b1, SpeedFast, 1'b0, 1'b0, a_q};
            state_q     <= START_A;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        START_A: state_q <= WAIT_A;
        WAIT_A: begin
          if (dac_done) begin
            cnt_q   <= GapLoad;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          // The IDLE cycle that follows adds one more cycle of margin before
          // the next START_B.
          if (cnt_q == 4'd0) begin
            s_ready_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
`ifdef DAC_CTRL_PWRDN_EN
        START_P: state_q <= WAIT_A;
`endif
        default: begin
          s_ready_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_tlv5618_ctrl.sv
// tb/tb_dac_tlv5618_ctrl.sv - randomized self-checking bench for dac_tlv5618_ctrl
module tb_dac_tlv5618_ctrl;

  localparam int G   = 2;
  localparam bit SPD = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [11:0] s_data_a = 12'd0;
  logic [11:0] s_data_b = 12'd0;
  logic        s_ready;
  logic        busy;
  logic        dac_start;
  logic [15:0] dac_data;
  logic        dac_done;
  logic        ser_done = 1'b0;
  logic        spur_idle = 1'b0;
  logic        spur_gap = 1'b0;
  logic        pwrdn_req = 1'b0;
  bit          ser_stall = 1'b0;
  bit          inj_gap = 1'b0;

  assign dac_done = ser_done | spur_idle | spur_gap;

  always #5 clk = ~clk;

  dac_tlv5618_ctrl #(.SpeedFast(SPD), .GapCycles(G)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data_a  (s_data_a),
    .s_data_b  (s_data_b),
    .busy      (busy),
    .dac_start (dac_start),
    .dac_data  (dac_data),
    .dac_done  (dac_done)
`ifdef DAC_CTRL_PWRDN_EN
    ,
    .pwrdn_req (pwrdn_req)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference words, from the TLV5618 bit weights.
  function automatic logic [15:0] wb_of(input logic [11:0] b);
    return 16'(int'(SPD) * 16384 + 4096 + int'(b));
  endfunction

  function automatic logic [15:0] wa_of(input logic [11:0] a);
    return 16'(32768 + int'(SPD) * 16384 + int'(a));
  endfunction

  // Scoreboard: expected words in order, observed words, and transaction tracking.
  logic [15:0] exp_q[$];
  logic [15:0] log_q[$];
  bit          outstanding = 1'b0;
  bit          prev_start = 1'b0;
  bit          lat_pend = 1'b0;
  bit          just_rel = 1'b0;
  int          idle_cnt = -1;
  logic [15:0] prev_data = 16'h0;
  logic [15:0] exp_w;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_s_ready", s_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_dac_start", dac_start, 0);
      check("rst_dac_data", dac_data, 0);
      exp_q.delete();
      outstanding = 1'b0;
      prev_start  = 1'b0;
      lat_pend    = 1'b0;
      just_rel    = 1'b1;
      idle_cnt    = -1;
      prev_data   = 16'h0;
    end else begin
      if (just_rel) just_rel = 1'b0;
      else check("ready_rule", s_ready, 32'(!busy && !pwrdn_req));
      if (lat_pend) begin
        check("start_latency", dac_start, 1);
        lat_pend = 1'b0;
      end
      if (!dac_start) check("data_hold", dac_data, prev_data);
      if (dac_start) begin
        check("no_consec_start", prev_start, 0);
        check("start_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          check("word", dac_data, exp_w);
          if (exp_w[15]) check("gap_b_to_a", idle_cnt, G);
          else if (idle_cnt >= 0) check("gap_to_b", 32'(idle_cnt >= G), 1);
        end
        log_q.push_back(dac_data);
        outstanding = 1'b1;
        idle_cnt    = -1;
      end else if (dac_done && outstanding) begin
        outstanding = 1'b0;
        idle_cnt    = 0;
      end else if (idle_cnt >= 0) begin
        idle_cnt++;
      end
      if (s_valid && s_ready) begin
        exp_q.push_back(wb_of(s_data_b));
        exp_q.push_back(wa_of(s_data_a));
        lat_pend = 1'b1;
      end
      prev_start = dac_start;
      prev_data  = dac_data;
    end
  end

  // Serializer model: done pulse N cycles after start, dropped on reset.
  initial begin
    int          n;
    logic [15:0] word;
    bit          abort;
    forever begin
      @(negedge clk);
      if (rst_n && dac_start) begin
        word  = dac_data;
        n     = ser_stall ? 40 : int'($urandom_range(1, 5));
        abort = 1'b0;
        for (int i = 0; i < n; i++) begin
          @(posedge clk);
          if (!rst_n) begin
            abort = 1'b1;
            break;
          end
        end
        if (!abort) begin
          #2 ser_done = 1'b1;
          @(posedge clk);
          #2 ser_done = 1'b0;
          if (inj_gap && !word[15]) begin
            spur_gap = 1'b1;
            @(posedge clk);
            #2 spur_gap = 1'b0;
          end
        end
      end
    end
  end

  task automatic put(input logic [11:0] a, input logic [11:0] b);
    bit ok = 1'b0;
    @(posedge clk);
    #2;
    s_valid  = 1'b1;
    s_data_a = a;
    s_data_b = b;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("handshake_timeout", ok, 1);
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && !outstanding) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_timeout", ok, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    logic [11:0] ra, rb;
    int          gap;

    // Reset
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("ready_at_release", s_ready, 0);
    @(negedge clk);
    check("ready_after_release", s_ready, 1);

    // Single pair
    log_q.delete();
    put(12'h123, 12'hABC);
    s_valid = 1'b0;
    wait_idle();
    check("t2_frames", log_q.size(), 2);
    check("t2_wb", (log_q.size() > 0) ? log_q[0] : 16'h0, 16'h5ABC);
    check("t2_wa", (log_q.size() > 1) ? log_q[1] : 16'h0, 16'hC123);

    // Back-to-back, s_valid held
    log_q.delete();
    for (int i = 0; i < 3; i++) put(12'($urandom), 12'($urandom));
    s_valid = 1'b0;
    wait_idle();
    check("t3_frames", log_q.size(), 6);

    // Spurious done in IDLE, then in GAP
    @(posedge clk);
    #2 spur_idle = 1'b1;
    @(posedge clk);
    #2 spur_idle = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("spur_idle_start", dac_start, 0);
      check("spur_idle_busy", busy, 0);
    end
    inj_gap = 1'b1;
    put(12'($urandom), 12'($urandom));
    s_valid = 1'b0;
    wait_idle();
    inj_gap = 1'b0;

    // Reset while in WAIT_B
    ser_stall = 1'b1;
    put(12'($urandom), 12'($urandom));
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t5_busy_wait_b", busy, 1);
    check("t5_start_low", dac_start, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_data", dac_data, 0);
    check("t5_rst_busy", busy, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    ser_stall = 1'b0;
    log_q.delete();
    ra = 12'($urandom);
    rb = 12'($urandom);
    put(ra, rb);
    s_valid = 1'b0;
    wait_idle();
    check("t5_restart_wb", (log_q.size() > 0) ? log_q[0] : 16'h0, wb_of(rb));

    // Randomized traffic
    for (int i = 0; i < 20; i++) begin
      gap = int'($urandom_range(0, 3));
      if (gap > 0) begin
        s_valid = 1'b0;
        repeat (gap) @(posedge clk);
      end
      put(12'($urandom), 12'($urandom));
    end
    s_valid = 1'b0;
    wait_idle();

`ifdef DAC_CTRL_PWRDN_EN
    // Power-down request wins over a pending pair
    log_q.delete();
    exp_q.push_back(16'(int'(SPD) * 16384 + 8192));
    @(posedge clk);
    #2;
    pwrdn_req = 1'b1;
    s_valid   = 1'b1;
    s_data_a  = 12'($urandom);
    s_data_b  = 12'($urandom);
    repeat (30) @(negedge clk);
    check("pd_frames", log_q.size(), 1);
    check("pd_word", (log_q.size() > 0) ? log_q[0] : 16'h0, 16'h6000);
    check("pd_ready_low", s_ready, 0);
    @(posedge clk);
    #2;
    s_valid   = 1'b0;
    pwrdn_req = 1'b0;
    log_q.delete();
    put(12'h000, 12'hFFF);
    s_valid = 1'b0;
    wait_idle();
    check("pu_wb", (log_q.size() > 0) ? log_q[0] : 16'h0, 16'h5FFF);
    check("pu_wa", (log_q.size() > 1) ? log_q[1] : 16'h0, 16'hC000);
`endif

    check("end_queue_empty", exp_q.size(), 0);
    check("end_no_outstanding", outstanding, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
